// File: rtl/pla_enc_pkg.sv
// Shared defaults and FSM state type for the strobe-word to index-stream encoder.
// Optional parity logic is enabled by defining PLA_OUT_ENCODER_PARITY_EN.
package pla_enc_pkg;

    localparam int W_DEF      = 18;
    localparam int CODE_W_DEF = 5;
    localparam int NONE_CODE  = (1 << CODE_W_DEF) - 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

endpackage

// File: rtl/pla_out_encoder_lsb_index_find.sv
// Lowest-set-bit locator: index, any-set flag and exactly-one-set flag.
// Purely combinational; shared by the capture and beat-advance paths.
module lsb_index_find
    import pla_enc_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [W-1:0]      vec,
    output logic [CODE_W-1:0] idx,
    output logic              any_set,
    output logic              one_set
);

    logic [W-1:0] rest;

    always_comb begin
        idx = '0;
        // Scan from the top so the lowest set bit wins.
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign rest    = vec & (vec - W'(1));
    assign any_set = |vec;
    assign one_set = any_set & ~(|rest);

endmodule

// File: rtl/pla_out_encoder.sv
// Re-encodes a decoded strobe word into a stream of set-bit indices, lowest first.
// Define PLA_OUT_ENCODER_PARITY_EN to add out_par and the par_err protocol checker.
module pla_out_encoder
    import pla_enc_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      dec_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
`ifdef PLA_OUT_ENCODER_PARITY_EN
    output logic              out_par,
    output logic              par_err,
`endif
    output logic [CODE_W-1:0] out_cnt
);

    localparam logic [CODE_W-1:0] NONE_VAL = '1;

    state_t              state;
    logic [W-1:0]        pending;
    logic [W-1:0]        pend_clr;
    logic [W-1:0]        nxt_vec;
    logic [CODE_W-1:0]   nxt_idx;
    logic                nxt_any;
    logic                nxt_one;
    logic                accept;
    logic                fire;

    function automatic logic [CODE_W-1:0] popcnt(input logic [W-1:0] v);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + CODE_W'(v[i]);
        end
        return c;
    endfunction

    assign fire     = out_valid & out_ready;
    assign in_ready = (state == IDLE) | ((state == EMIT) & fire & out_last);
    assign accept   = in_valid & in_ready;
    assign pend_clr = pending & (pending - W'(1));
    // A fresh word takes priority over advancing the one just finished.
    assign nxt_vec  = accept ? dec_in : pend_clr;

    lsb_index_find #(
        .W      (W),
        .CODE_W (CODE_W)
    ) u_find (
        .vec     (nxt_vec),
        .idx     (nxt_idx),
        .any_set (nxt_any),
        .one_set (nxt_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_last  <= 1'b0;
            out_cnt   <= '0;
        end else if (accept) begin
            state     <= EMIT;
            pending   <= dec_in;
            out_valid <= 1'b1;
            out_code  <= nxt_any ? nxt_idx : NONE_VAL;
            out_last  <= nxt_one | ~nxt_any;
            out_cnt   <= popcnt(dec_in);
        end else if (fire) begin
            pending <= pend_clr;
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                out_code <= nxt_idx;
                out_last <= nxt_one;
            end
        end
    end

`ifdef PLA_OUT_ENCODER_PARITY_EN
    logic [W-1:0] dec_q;
    logic         stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
            dec_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            dec_q   <= dec_in;
            stall_q <= in_valid & ~in_ready;
            if (accept) begin
                out_par <= ^dec_in;
            end
        end
    end

    // Producer must hold its word steady while stalled.
    assign par_err = stall_q & in_valid & (dec_in != dec_q);
`endif

endmodule

// File: tb/tb_pla_out_encoder.sv
// Directed self-checking bench for pla_out_encoder.
// Parity checks compile in when PLA_OUT_ENCODER_PARITY_EN is defined.
module tb_pla_out_encoder;

    localparam int W      = 18;
    localparam int CODE_W = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      dec_in;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic [CODE_W-1:0] out_cnt;
`ifdef PLA_OUT_ENCODER_PARITY_EN
    logic              out_par;
    logic              par_err;
`endif

    int checks;
    int errors;

    pla_out_encoder #(
        .W      (W),
        .CODE_W (CODE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec_in    (dec_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
`ifdef PLA_OUT_ENCODER_PARITY_EN
        .out_par   (out_par),
        .par_err   (par_err),
`endif
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dec_in    = '0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, out_code, out_last, out_cnt} !== {1'b1, 1'b0, 5'd0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_hold rdy=%b vld=%b code=%0d last=%b cnt=%0d want 1 0 0 0 0",
                     in_ready, out_valid, out_code, out_last, out_cnt);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, out_code, out_cnt} !== {1'b1, 1'b0, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset_release rdy=%b vld=%b code=%0d cnt=%0d want 1 0 0 0",
                     in_ready, out_valid, out_code, out_cnt);
        end
    endtask

    task automatic test_two_bits();
        dec_in    = 18'h00005;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_code, out_last, out_cnt, in_ready} !== {1'b1, 5'd0, 1'b0, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL two_beat0 vld=%b code=%0d last=%b cnt=%0d rdy=%b want 1 0 0 2 0",
                     out_valid, out_code, out_last, out_cnt, in_ready);
        end
        step();
        checks++;
        if ({out_valid, out_code, out_last, out_cnt, in_ready} !== {1'b1, 5'd2, 1'b1, 5'd2, 1'b1}) begin
            errors++;
            $display("FAIL two_beat1 vld=%b code=%0d last=%b cnt=%0d rdy=%b want 1 2 1 2 1",
                     out_valid, out_code, out_last, out_cnt, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_idle vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_zero_full();
        dec_in   = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_code, out_last, out_cnt} !== {1'b1, 5'd31, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL zero_word vld=%b code=%0d last=%b cnt=%0d want 1 31 1 0",
                     out_valid, out_code, out_last, out_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle vld=%b want 0", out_valid);
        end
        dec_in   = 18'h3FFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            checks++;
            if ({out_valid, out_code, out_last, out_cnt} !== {1'b1, 5'(i), (i == 17), 5'd18}) begin
                errors++;
                $display("FAIL full_beat%0d vld=%b code=%0d last=%b cnt=%0d want 1 %0d %0d 18",
                         i, out_valid, out_code, out_last, out_cnt, i, (i == 17));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_idle vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_ignore();
        out_ready = 1'b0;
        dec_in    = 18'h00006;
        in_valid  = 1'b1;
        step();
        dec_in = 18'h00001;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({out_code, out_cnt, in_ready} !== {5'd1, 5'd2, 1'b0}) begin
                errors++;
                $display("FAIL ignore_stall%0d code=%0d cnt=%0d rdy=%b want 1 2 0",
                         i, out_code, out_cnt, in_ready);
            end
        end
        in_valid  = 1'b0;
        dec_in    = 18'h3FFFF;
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_code, out_last, out_cnt} !== {1'b1, 5'd2, 1'b1, 5'd2}) begin
            errors++;
            $display("FAIL ignore_beat1 vld=%b code=%0d last=%b cnt=%0d want 1 2 1 2",
                     out_valid, out_code, out_last, out_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        dec_in    = 18'h20001;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, out_code, out_last, out_cnt} !== {1'b1, 5'd0, 1'b0, 5'd2}) begin
                errors++;
                $display("FAIL bp_hold%0d vld=%b code=%0d last=%b cnt=%0d want 1 0 0 2",
                         i, out_valid, out_code, out_last, out_cnt);
            end
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step();
        dec_in   = 18'h00100;
        in_valid = 1'b1;
        #1;
        checks++;
        if ({out_code, out_last, in_ready} !== {5'd17, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL bp_last code=%0d last=%b rdy=%b want 17 1 1",
                     out_code, out_last, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_code, out_last, out_cnt} !== {1'b1, 5'd8, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL b2b_next vld=%b code=%0d last=%b cnt=%0d want 1 8 1 1",
                     out_valid, out_code, out_last, out_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle vld=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        dec_in   = 18'h000F0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_code !== 5'd4) begin
            errors++;
            $display("FAIL mid_beat0 code=%0d want 4", out_code);
        end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        step();
        rst_n    = 1'b1;
        dec_in   = 18'h00002;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_code, out_last, out_cnt} !== {1'b1, 5'd1, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL mid_after vld=%b code=%0d last=%b cnt=%0d want 1 1 1 1",
                     out_valid, out_code, out_last, out_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle vld=%b want 0", out_valid);
        end
    endtask

`ifdef PLA_OUT_ENCODER_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        dec_in    = 18'h00007;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_par, out_code} !== {1'b1, 5'(i)}) begin
                errors++;
                $display("FAIL par_beat%0d par=%b code=%0d want 1 %0d", i, out_par, out_code, i);
            end
            step();
        end
        out_ready = 1'b0;
        dec_in    = 18'h00003;
        in_valid  = 1'b1;
        step();
        dec_in = 18'h00005;
        #1;
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_err_quiet err=%b want 0", par_err);
        end
        step();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_err_held err=%b want 0", par_err);
        end
        dec_in = 18'h00009;
        #1;
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL par_err_pulse err=%b want 1", par_err);
        end
        step();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_err_clear err=%b want 0", par_err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL par_idle vld=%b want 0", out_valid);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_two_bits();
        test_zero_full();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef PLA_OUT_ENCODER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pla_out_encoder.md
Name: pla_out_encoder

Overview:
- Inverse-side companion to the team's misex2-style combinational control decoders (25 in / 18 out).
- Accepts one W-bit decoded strobe word per handshake.
- Re-encodes the word into a serial stream of binary output indices, lowest index first, over a valid/ready interface.
- Sits between a decoder's output bus and a narrow logging or replay channel. It lets a bench or downstream sequencer reconstruct which decoder outputs fired.

Parameters:
- W, 18, width of the decoded strobe word.
- CODE_W, 5, width of an emitted index code; must satisfy 2**CODE_W - 1 >= W.
- NONE_CODE, 2**CODE_W-1 (31), code emitted for an all-zero word.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dec_in holds a word to encode.
- in_ready  output  1  block can accept a word this cycle.
- dec_in  input  W  decoded strobe word; bit i corresponds to output index i.
- out_valid  output  1  out_code/out_last/out_cnt are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_code  output  CODE_W  index of the current set bit, or NONE_CODE.
- out_last  output  1  current beat is the final beat for this word.
- out_cnt  output  CODE_W  popcount of the word being emitted, constant across its beats; 0 for an all-zero word.

Behaviour:
- Reset: asynchronous on rst_n low; the block stays in reset while rst_n is low.
  - state=IDLE, pending=0, out_valid=0, out_code=0, out_last=0, out_cnt=0, in_ready=1.
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid & in_ready, capture dec_in into pending and the popcount into out_cnt, then go to EMIT.
  - Latency: the first beat is valid in the cycle after acceptance.
- EMIT:
  - out_code = index of the lowest set bit of pending.
  - out_last=1 iff pending has exactly one set bit.
  - If pending==0 (captured word was zero): out_code=NONE_CODE and out_last=1.
  - out_valid=1.
- Beat transfer (out_valid & out_ready):
  - Clear the lowest set bit of pending.
  - If out_last, go to IDLE.
- Backpressure: while out_ready=0, out_code, out_last and out_cnt are held stable. pending does not change.
- Back-to-back words: in_ready = IDLE | (EMIT & out_valid & out_ready & out_last).
  - A new word may be accepted in the same cycle the final beat transfers; the block then stays in EMIT.
  - Zero bubble cycles between words.
- Throughput: a word with k set bits takes max(k,1) beats.
- in_valid while in_ready=0 is ignored; the word is not captured.
- dec_in is sampled only at acceptance; later changes have no effect.
- Reset mid-word: pending is discarded, the remaining beats are lost, and the block returns to IDLE.
- Widths: popcount has a range of 0..W and fits in CODE_W by the parameter constraint. No wrap-around is possible.

Optional Feature:
- Macro PLA_OUT_ENCODER_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = XOR of the captured word, held constant across all beats of that word; reset value 0.
  - Adds a checker output par_err (1 bit), asserted for one cycle if dec_in changes while in_valid=1 and in_ready=0. This flags a protocol violation by the producer.
- When undefined: neither port exists and the logic is otherwise identical.

Decomposition:
- Package pla_enc_pkg: parameter defaults W and CODE_W, the NONE_CODE constant, and the state enum {IDLE, EMIT}.
- One sub-module, lsb_index_find, which is combinational. It takes a W-bit vector and returns:
  - index of the lowest set bit (CODE_W bits);
  - an any-set flag;
  - a single-bit flag (exactly one bit set).
- The popcount stays inline in pla_out_encoder.

Test Plan:
- Reset: rst_n low, then release -> in_ready=1, out_valid=0, out_code=0, out_cnt=0.
- Word with out_ready tied 1: dec_in=18'h00005 accepted at cycle N -> cycle N+1 beat (code 0, last 0, cnt 2); cycle N+2 beat (code 2, last 1, cnt 2); in_ready high in cycle N+2.
- Zero and full words: dec_in=0 -> single beat code 31, last 1, cnt 0. dec_in=18'h3FFFF -> 18 beats with codes 0..17, only the 18th has last=1, cnt=18 throughout.
- Backpressure and back-to-back: dec_in=18'h20001 with out_ready low for 3 cycles -> code 0 held for 3 cycles, then codes 0 and 17. A second word 18'h00100 offered during the last beat is accepted in that cycle, and code 8 follows with no bubble.
- Reset mid-word: 18'h000F0 with rst_n pulsed low after the first beat -> out_valid=0 immediately. After release, a new word 18'h00002 emits only code 1.
- Parity feature (PLA_OUT_ENCODER_PARITY_EN):
  - dec_in=18'h00007 -> out_par=1 on all 3 beats.
  - Changing dec_in while in_ready=0 with in_valid=1 -> par_err pulses once.
